bcd_seg_counter: RTL

BCD_SEG_COUNTER -- requirements
Module: bcd_seg_counter

---
 rtl/bcd_seg_counter_pkg.sv | 52 +++++
 rtl/bcd_seg_counter_btn_debounce.sv | 98 +++++++++
 rtl/bcd_seg_counter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_seg_counter_pkg.sv
// Shared package myPkg: segment codes, BCD-to-segment encoder, step clamp and FSM state enums
// for the bcd_seg_counter slice.
package myPkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_D0    = 8'hC0;
    localparam logic [7:0] SEG_D1    = 8'hF9;
    localparam logic [7:0] SEG_D2    = 8'hA4;
    localparam logic [7:0] SEG_D3    = 8'hB0;
    localparam logic [7:0] SEG_D4    = 8'h99;
    localparam logic [7:0] SEG_D5    = 8'h92;
    localparam logic [7:0] SEG_D6    = 8'h82;
    localparam logic [7:0] SEG_D7    = 8'hF8;
    localparam logic [7:0] SEG_D8    = 8'h80;
    localparam logic [7:0] SEG_D9    = 8'h90;

    typedef enum logic [1:0] {
        DB_IDLE       = 2'd0,
        DB_PRESS_WAIT = 2'd1,
        DB_HELD       = 2'd2,
        DB_REL_WAIT   = 2'd3
    } db_state_e;

    typedef enum logic {
        CNT_IDLE   = 1'b0,
        CNT_UPDATE = 1'b1
    } cnt_state_e;

    // Non-BCD codes fall back to blank so a corrupted digit never shows a bogus glyph.
    function automatic logic [7:0] bcd_to_seg(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = SEG_D0;
            4'd1:    code = SEG_D1;
            4'd2:    code = SEG_D2;
            4'd3:    code = SEG_D3;
            4'd4:    code = SEG_D4;
            4'd5:    code = SEG_D5;
            4'd6:    code = SEG_D6;
            4'd7:    code = SEG_D7;
            4'd8:    code = SEG_D8;
            4'd9:    code = SEG_D9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] clamp_step(input logic [3:0] step);
        return (step > 4'd9) ? 4'd9 : step;
    endfunction

endpackage

// File: rtl/bcd_seg_counter_btn_debounce.sv
// Two-flop synchronizer plus debouncer FSM for the active-low push button; emits a
// one-cycle o_press pulse per accepted press and requires a debounced release before re-arming.
module btn_debounce
    import myPkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic o_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       r_sync;
    db_state_e        r_state;
    db_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             w_sync;

    assign w_sync  = r_sync[1];
    assign o_press = r_press;

    // Synchronizer resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], btn};
        end
    end

    // Debouncer state, stability counter and registered accept pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DB_IDLE;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press_nxt;
        end
    end

    // r_cnt holds the number of consecutive matching samples already seen in a WAIT state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_press_nxt = 1'b0;
        case (r_state)
            DB_IDLE: begin
                if (!w_sync) begin
                    w_state_nxt = DB_PRESS_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_state_nxt = DB_IDLE;
                end
            end
            DB_PRESS_WAIT: begin
                if (w_sync) begin
                    w_state_nxt = DB_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DB_HELD;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DB_HELD: begin
                if (w_sync) begin
                    w_state_nxt = DB_REL_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_state_nxt = DB_HELD;
                end
            end
            DB_REL_WAIT: begin
                if (!w_sync) begin
                    w_state_nxt = DB_HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DB_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = DB_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/bcd_seg_counter.sv
// Debounced push-button BCD up/down counter driving NUM_DIGITS seven-segment displays.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module bcd_seg_counter
    import myPkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic [3:0] sw,
    input  logic       up_dn,
    output logic [7:0] seg [0:NUM_DIGITS-1],
    output logic       busy,
    output logic       wrap
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                       w_press;
    cnt_state_e                 r_state;
    cnt_state_e                 w_state_nxt;
    logic [NUM_DIGITS-1:0][3:0] r_disp;
    logic [NUM_DIGITS-1:0][3:0] r_shadow;
    logic [NUM_DIGITS-1:0][3:0] w_shadow_nxt;
    logic [NUM_DIGITS-1:0][3:0] w_disp_nxt;
    logic [3:0]                 r_step;
    logic                       r_up;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_carry;
    logic                       r_busy;
    logic                       r_wrap;
    logic [7:0]                 r_seg     [0:NUM_DIGITS-1];
    logic [7:0]                 w_seg_nxt [0:NUM_DIGITS-1];
    logic                       w_last;
    logic [3:0]                 w_cur;
    logic [3:0]                 w_operand;
    logic                       w_cin;
    logic [4:0]                 w_sum;
    logic [4:0]                 w_sum_adj;
    logic [4:0]                 w_diff;
    logic [3:0]                 w_digit_nxt;
    logic                       w_cout;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .o_press (w_press)
    );

    assign seg  = r_seg;
    assign busy = r_busy;
    assign wrap = r_wrap;
    assign w_last = (r_state == CNT_UPDATE) && (r_idx == LAST_IDX);

    // Counter FSM next state; presses arriving mid-update are dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CNT_IDLE: begin
                if (w_press) begin
                    w_state_nxt = CNT_UPDATE;
                end else begin
                    w_state_nxt = CNT_IDLE;
                end
            end
            CNT_UPDATE: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = CNT_IDLE;
                end else begin
                    w_state_nxt = CNT_UPDATE;
                end
            end
            default: begin
                w_state_nxt = CNT_IDLE;
            end
        endcase
    end

    // One BCD digit add/subtract; only digit 0 sees the step, the rest only the carry/borrow.
    always_comb begin
        w_cur       = r_shadow[r_idx];
        w_operand   = (r_idx == '0) ? r_step : 4'd0;
        w_cin       = (r_idx == '0) ? 1'b0 : r_carry;
        w_sum       = {1'b0, w_cur} + {1'b0, w_operand} + {4'd0, w_cin};
        w_sum_adj   = w_sum - 5'd10;
        w_diff      = {1'b0, w_cur} - {1'b0, w_operand} - {4'd0, w_cin};
        w_digit_nxt = 4'd0;
        w_cout      = 1'b0;
        if (r_up) begin
            if (w_sum > 5'd9) begin
                w_digit_nxt = w_sum_adj[3:0];
                w_cout      = 1'b1;
            end else begin
                w_digit_nxt = w_sum[3:0];
                w_cout      = 1'b0;
            end
        end else begin
            if (w_diff[4]) begin
                w_digit_nxt = w_diff[3:0] + 4'd10;
                w_cout      = 1'b1;
            end else begin
                w_digit_nxt = w_diff[3:0];
                w_cout      = 1'b0;
            end
        end
        w_shadow_nxt        = r_shadow;
        w_shadow_nxt[r_idx] = w_digit_nxt;
        w_disp_nxt          = w_last ? w_shadow_nxt : r_disp;
    end

    // Segment encode of the value the display register will hold after this edge.
`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic v_lead;
        v_lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if ((i != 0) && v_lead && (w_disp_nxt[i] == 4'd0)) begin
                w_seg_nxt[i] = SEG_BLANK;
            end else begin
                v_lead       = 1'b0;
                w_seg_nxt[i] = bcd_to_seg(w_disp_nxt[i]);
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_seg_nxt[i] = bcd_to_seg(w_disp_nxt[i]);
        end
    end
`endif

    // Counter datapath, status flags and registered segment outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= CNT_IDLE;
            r_disp   <= '0;
            r_shadow <= '0;
            r_step   <= 4'd0;
            r_up     <= 1'b1;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_wrap   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
                r_seg[i] <= (i == 0) ? SEG_D0 : SEG_BLANK;
`else
                r_seg[i] <= SEG_D0;
`endif
            end
        end else begin
            r_state <= w_state_nxt;
            r_disp  <= w_disp_nxt;
            r_seg   <= w_seg_nxt;
            r_wrap  <= 1'b0;
            case (r_state)
                CNT_IDLE: begin
                    if (w_press) begin
                        r_step   <= clamp_step(sw);
                        r_up     <= up_dn;
                        r_idx    <= '0;
                        r_carry  <= 1'b0;
                        r_shadow <= r_disp;
                        r_busy   <= 1'b1;
                    end
                end
                CNT_UPDATE: begin
                    r_shadow <= w_shadow_nxt;
                    r_carry  <= w_cout;
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_wrap <= w_cout;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
